// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key debounce, one-cycle strobe and held level.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_TICKS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         row_q, row_d;
  logic [1:0]         r_q, r_d;
  logic [1:0]         c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   relcnt_q, relcnt_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               held_q, held_d;

  logic               tick;
  logic [3:0]         row_rot;
  logic [1:0]         cur_row;
  logic [1:0]         low_col;
  logic               watched_open;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   relcnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);

  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   rep_inc;

  assign rep_inc = rep_q + REP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

  assign tick         = (div_q == DIV_LAST);
  assign row_rot      = {row_q[2:0], row_q[3]};
  assign watched_open = keypad_col[c_q];
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign relcnt_inc   = relcnt_q + CNT_W'(1);

  always_comb begin
    cur_row = 2'd0;
    case (row_q)
      4'b1110: cur_row = 2'd0;
      4'b1101: cur_row = 2'd1;
      4'b1011: cur_row = 2'd2;
      4'b0111: cur_row = 2'd3;
      default: cur_row = 2'd0;
    endcase
  end

  // Scanning downward leaves the lowest-index closed column as the winner.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!keypad_col[i]) begin
        low_col = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      div_q    <= '0;
      row_q    <= 4'b1110;
      r_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      relcnt_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      row_q    <= row_d;
      r_q      <= r_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      relcnt_q <= relcnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    row_d    = row_q;
    r_d      = r_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    relcnt_d = relcnt_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    held_d   = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (keypad_col == 4'b1111) begin
            row_d = row_rot;
          end else begin
            r_d     = cur_row;
            c_d     = low_col;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (!watched_open) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              code_d   = {r_q, c_q};
              valid_d  = 1'b1;
              held_d   = 1'b1;
              relcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d    = '0;
`endif
              state_d  = HELD;
            end
          end else begin
            row_d   = row_rot;
            state_d = SCAN;
          end
        end

        HELD: begin
          if (watched_open) begin
            relcnt_d = relcnt_inc;
`ifdef KEYPAD_REPEAT_EN
            rep_d    = '0;
`endif
            if (relcnt_inc == DB_LAST) begin
              held_d  = 1'b0;
              row_d   = row_rot;
              state_d = SCAN;
            end
          end else begin
            relcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // The repeat strobe reuses the published code; only the pulse is new.
            if (rep_inc == REP_LAST) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d   = rep_inc;
            end
`endif
          end
        end

        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  assign keypad_row = row_q;
  assign key_code   = code_q;
  assign key_valid  = valid_q;
  assign key_held   = held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad that the game boards share with the dot-matrix display. It drives one active-low row at a time and samples the returned active-low columns. Each press is debounced and reported as a 4-bit key code with a one-cycle valid strobe plus a held level. It is the host-side reader of the keypad row/column interface and feeds the game logic in place of ad-hoc per-game scanning.

## Interface
- CLK_DIV, 4: clk cycles per scan tick; legal range ≥2.
- DEBOUNCE_SCANS, 3: consecutive ticks a press or release must persist; legal range ≥2.
- REPEAT_TICKS, 5: ticks between auto-repeat strobes; used only with KEYPAD_REPEAT_EN.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- keypad_col  in  4  column sense, active-low; bit c low means a key in column c of the driven row is closed.
- keypad_row  out  4  row drive, active-low one-hot; row r is driven when bit r is 0.
- key_code  out  4  last debounced key, equal to 4*r + c.
- key_valid  out  1  one-cycle strobe when a new key_code is published.
- key_held  out  1  high from publication until the release is debounced.

## Operation
- Tick divider: counter runs 0..CLK_DIV-1 and wraps; tick is high for one cycle when the count is CLK_DIV-1. All sampling and state moves happen only on tick cycles.
- Reset values: keypad_row=4'b1110, key_code=0, key_valid=0, key_held=0, divider=0, state=SCAN, all counters 0.
- States: SCAN, DEBOUNCE, HELD.
- SCAN, on tick:
  - If keypad_col=4'b1111: rotate the row, 1110→1101→1011→0111→1110.
  - Otherwise: latch r (the current row) and c (the lowest-index low column bit), set cnt=1, go to DEBOUNCE. The row does not rotate.
- DEBOUNCE: row is frozen. On tick:
  - If keypad_col[c]=0: cnt+1. When cnt reaches DEBOUNCE_SCANS: key_code←{r,c}, key_valid=1 for one cycle, key_held←1, relcnt=0, go to HELD.
  - If keypad_col[c]=1: go to SCAN and rotate the row. Nothing is published and key_code is unchanged.
- HELD: row is frozen. On tick:
  - If keypad_col[c]=1: relcnt+1. When relcnt reaches DEBOUNCE_SCANS: key_held←0, go to SCAN, rotate the row.
  - If keypad_col[c]=0: relcnt←0.
- Only column c of the latched row is watched in DEBOUNCE and HELD. Other keys pressed meanwhile are ignored until SCAN resumes.
- Multiple low columns in the same row: the lowest index wins, so (1,0) and (1,3) together give code 4.
- key_code holds its value indefinitely between publications.
- Reset asserted in any state, including mid-DEBOUNCE or HELD, restores the reset values on the next clk edge. No strobe is emitted.

## Timing
- keypad_row changes on the clk edge that ends a tick cycle. The driven row therefore settles for a full CLK_DIV cycles before its next sample.
- Let T0 be the tick cycle that first detects a press. key_valid is high in cycle T0 + (DEBOUNCE_SCANS-1)*CLK_DIV + 1. It is registered, so it lands one cycle after the qualifying tick.
- key_code and key_held update in the same cycle that key_valid rises.
- Release: key_held falls one cycle after the DEBOUNCE_SCANS-th consecutive released tick.
- Scan rate: one row per CLK_DIV cycles; full keypad every 4*CLK_DIV cycles while idle.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter counts ticks with the key still closed.
  - Every REPEAT_TICKS such ticks, key_valid pulses one cycle with the same key_code.
  - Any released tick resets the repeat counter.
  - The first repeat occurs REPEAT_TICKS ticks after the initial strobe.
- KEYPAD_REPEAT_EN undefined: the repeat counter is absent; exactly one key_valid per press; REPEAT_TICKS is ignored.

## Test plan
Bench keypad model: keypad_col[c]=0 iff keypad_row[r]=0 and key (r,c) is pressed. Parameters CLK_DIV=4, DEBOUNCE_SCANS=3.
- Reset: rst high 3 cycles → keypad_row=1110 and all outputs 0. After release, the row rotates every 4 cycles through 1101, 1011, 0111, 1110. Reset mid-HELD clears key_held and returns the row to 1110 on the next edge.
- Clean press of (2,1) held 40 cycles → key_code=9, key_valid high exactly 1 cycle, 9 cycles after the detection tick; key_held=1. On release, key_held falls 9 cycles after the first released tick.
- Bounce: (0,3) closed for one tick only → no key_valid, key_code unchanged, scan resumes rotating from row 0.
- Simultaneous (1,0) and (1,3) → key_code=4. Pressing (3,2) during HELD produces no strobe.
- With KEYPAD_REPEAT_EN and REPEAT_TICKS=5, (3,3) held 100 cycles → key_code=15; strobes at the initial cycle, then every 20 cycles. Without the macro, the same stimulus gives exactly one strobe.
